uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing the single UART transmitter among NUM_REQ byte-stream requesters. It grants one requester at a time and frames its message as one header byte carrying the requester index, followed by the payload bytes up to and including the byte flagged last. Each byte is driven through the transmitter's tx_start/tx_data/tx_busy handshake. It sits between the message producers and the tx side of the uart block.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        FETCH,
        GAP
    } arb_state_t;

    localparam logic [7:0] HDR_PREFIX = 8'h80;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search begins at the index after last_idx
// and wraps, so the previous winner is always considered last.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_REQ);

    int cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_idx) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any        = 1'b1;
                winner_idx = IW'(cand);
            end
        end
        if (any) winner[winner_idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: each grant sends a
// header byte (8'h80 | index) followed by the requester's payload bytes.
//
// state   | meaning
// IDLE    | free; arbitrate when any request and transmitter idle
// SEND    | tx_start pulse cycle
// WAIT_HI | waiting for transmitter to report busy
// WAIT_LO | waiting for transmitter to finish the byte
// FETCH   | req_ready to owner; take next payload byte
// GAP     | grant released; idle spacing before next arbitration
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic                 err_trunc
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    arb_state_t          state;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       byte_cnt;
    logic                is_last;
    logic [GW-1:0]       gap_cnt;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IW-1:0]       win_idx;
    logic                win_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_idx   (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    assign req_ready = (state == FETCH) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            gidx          <= '0;
            rr_ptr        <= IW'(NUM_REQ - 1);
            byte_cnt      <= '0;
            is_last       <= 1'b0;
            gap_cnt       <= '0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= 8'h00;
            err_trunc     <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any && !uart_tx_busy) begin
                        grant         <= win_onehot;
                        gidx          <= win_idx;
                        uart_tx_data  <= HDR_PREFIX | 8'(win_idx);
                        uart_tx_start <= 1'b1;
                        byte_cnt      <= '0;
                        is_last       <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    uart_tx_start <= 1'b0;
                    state         <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (uart_tx_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    // Grant drops with the final busy fall so the whole gap is grant-free.
                    if (!uart_tx_busy) begin
                        if (is_last || byte_cnt == MAX_CNT) begin
                            err_trunc <= !is_last;
                            grant     <= '0;
                            gap_cnt   <= GAP_LOAD;
                            state     <= GAP;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (req_valid[gidx]) begin
                        uart_tx_data  <= req_data[{gidx, 3'b000} +: 8];
                        uart_tx_start <= 1'b1;
                        is_last       <= req_last[gidx];
                        byte_cnt      <= byte_cnt + 1'b1;
                        state         <= SEND;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        rr_ptr <= gidx;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a delayed-busy UART model and
// queue-fed requesters.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int ML = 4;
    localparam int GC = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            uart_tx_start;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_busy;
    logic            err_trunc;

    logic busy_m   = 1'b0;
    logic ext_busy = 1'b0;
    assign uart_tx_busy = busy_m | ext_busy;

    int            dly  = 1;
    int            hold = 4;
    logic [NR-1:0] hold_off = '0;
    logic [NR-1:0] fire;
    logic [8:0]    rq [NR][$];
    logic [7:0]    q_data[$];
    logic [NR-1:0] q_grant[$];
    int            bad_start = 0;
    int            trunc_cnt = 0;
    logic          prev_start = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .GAP_CYCLES(GC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .grant         (grant),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_busy  (uart_tx_busy),
        .err_trunc     (err_trunc)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises dly clocks after a start, stays hold clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx_start === 1'b1) begin
                repeat (dly) @(posedge clk);
                #1 busy_m = 1'b1;
                repeat (hold) @(posedge clk);
                #1 busy_m = 1'b0;
            end
        end
    end

    // Requesters: present queue heads, pop on valid&ready.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0 && !hold_off[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = rq[i][0][7:0];
                    req_last[i]         = rq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*8 +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (uart_tx_start === 1'b1) begin
                q_data.push_back(uart_tx_data);
                q_grant.push_back(grant);
                if (uart_tx_busy || prev_start) bad_start++;
            end
            if (err_trunc === 1'b1) trunc_cnt++;
        end
        prev_start = uart_tx_start;
    end

    task automatic push(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int c = 0;
        while (q_data.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic clear_log();
        q_data.delete();
        q_grant.delete();
        trunc_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b required 0000", grant); end
        n_checks++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b required 0", uart_tx_start); end
        n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", uart_tx_data); end
        n_checks++; if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_trunc); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        logic [7:0]    exp_d[$];
        logic [NR-1:0] exp_g[$];
        bit ok;
        exp_d = '{8'h80, 8'hA0, 8'h81, 8'hA1, 8'h83, 8'hA3, 8'h80, 8'hB0, 8'h81, 8'hB1, 8'h83, 8'hB3};
        exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                  4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
        clear_log();
        @(negedge clk);
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(3, 8'hA3, 1'b1);
        push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1); push(3, 8'hB3, 1'b1);
        wait_bytes(12, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_timeout: got %0d starts required 12", q_data.size()); end
        repeat (40) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL contention_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
            n_checks++; if (q_grant[k] !== exp_g[k]) begin n_fail++; $display("FAIL contention_grant%0d: got %b required %b", k, q_grant[k], exp_g[k]); end
        end
        n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL contention_count: got %0d required 12", q_data.size()); end
    endtask

    task automatic test_single();
        logic [7:0]    exp_d[$];
        logic [NR-1:0] exp_g[$];
        bit ok;
        int c, gc;
        exp_d = '{8'h82, 8'h11, 8'h22, 8'h33, 8'h80, 8'h05};
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        clear_log();
        @(negedge clk);
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        wait_bytes(4, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d starts required 4", q_data.size()); end
        push(0, 8'h05, 1'b1);
        c = 0;
        while (uart_tx_busy !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        while (uart_tx_busy !== 1'b0 && c < 200) begin @(negedge clk); c++; end
        gc = 0;
        @(negedge clk);
        while (grant === 4'b0000 && gc < 100) begin gc++; @(negedge clk); end
        n_checks++; if (gc < GC || gc > GC + 1) begin n_fail++; $display("FAIL single_gap: got %0d idle clocks required %0d..%0d", gc, GC, GC + 1); end
        wait_bytes(6, 1000, ok);
        repeat (40) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
            n_checks++; if (q_grant[k] !== exp_g[k]) begin n_fail++; $display("FAIL single_grant%0d: got %b required %b", k, q_grant[k], exp_g[k]); end
        end
        n_checks++; if (trunc_cnt !== 0) begin n_fail++; $display("FAIL single_trunc: got %0d pulses required 0", trunc_cnt); end
    endtask

    task automatic test_truncation();
        logic [7:0] exp_d[$];
        bit ok;
        int first_trunc;
        exp_d = '{8'h81, 8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h05, 8'h06};
        clear_log();
        @(negedge clk);
        for (int b = 1; b <= 6; b++) push(1, 8'(b), b == 6);
        wait_bytes(6, 1000, ok);
        first_trunc = trunc_cnt;
        n_checks++; if (first_trunc !== 1) begin n_fail++; $display("FAIL trunc_pulse: got %0d pulses required 1", first_trunc); end
        wait_bytes(8, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL trunc_timeout: got %0d starts required 8", q_data.size()); end
        repeat (40) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL trunc_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
            n_checks++; if (q_grant[k] !== 4'b0010) begin n_fail++; $display("FAIL trunc_grant%0d: got %b required 0010", k, q_grant[k]); end
        end
        n_checks++; if (trunc_cnt !== 1) begin n_fail++; $display("FAIL trunc_total: got %0d pulses required 1", trunc_cnt); end
    endtask

    task automatic test_handshake();
        logic [7:0] exp_d[$];
        bit ok;
        exp_d = '{8'h83, 8'hC1, 8'hC2};
        clear_log();
        bad_start = 0;
        dly  = 3;
        hold = 20;
        @(negedge clk);
        push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b1);
        wait_bytes(3, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL handshake_timeout: got %0d starts required 3", q_data.size()); end
        repeat (80) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL handshake_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
        end
        n_checks++; if (q_data.size() !== 3) begin n_fail++; $display("FAIL handshake_count: got %0d required 3", q_data.size()); end
        n_checks++; if (bad_start !== 0) begin n_fail++; $display("FAIL handshake_start_rule: got %0d bad starts required 0", bad_start); end
        dly  = 1;
        hold = 4;
    endtask

    task automatic test_stall();
        logic [7:0] exp_d[$];
        bit ok, stall_ok;
        exp_d = '{8'h82, 8'h31, 8'h32, 8'h33};
        clear_log();
        @(negedge clk);
        push(2, 8'h31, 1'b0); push(2, 8'h32, 1'b0); push(2, 8'h33, 1'b1);
        wait_bytes(2, 1000, ok);
        @(negedge clk);
        hold_off[2] = 1'b1;
        stall_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (grant !== 4'b0100) stall_ok = 1'b0;
        end
        n_checks++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_grant_held: got %b required 1", stall_ok); end
        n_checks++; if (q_data.size() !== 2) begin n_fail++; $display("FAIL stall_no_start: got %0d starts required 2", q_data.size()); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_ready: got %b required 0100", req_ready); end
        hold_off[2] = 1'b0;
        wait_bytes(4, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d starts required 4", q_data.size()); end
        repeat (40) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL stall_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d[$];
        bit ok, idle_ok;
        int c;
        exp_d = '{8'h80, 8'h42, 8'h43};
        clear_log();
        @(negedge clk);
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        wait_bytes(2, 1000, ok);
        c = 0;
        while (uart_tx_busy !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        @(negedge clk);
        ext_busy = 1'b1;
        rst_n    = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b required 0000", grant); end
        n_checks++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b required 0", uart_tx_start); end
        n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h required 00", uart_tx_data); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b required 0000", req_ready); end
        clear_log();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (grant !== 4'b0000 || uart_tx_start !== 1'b0) idle_ok = 1'b0;
        end
        n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_busy: got %b required 1", idle_ok); end
        ext_busy = 1'b0;
        wait_bytes(3, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got %0d starts required 3", q_data.size()); end
        repeat (40) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (q_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h required %h", k, q_data[k], exp_d[k]); end
        end
        n_checks++; if (q_data.size() !== 3) begin n_fail++; $display("FAIL rstmid_count: got %0d required 3", q_data.size()); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_truncation();
        test_handshake();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
